// File: rtl/up_down_counter_pkg.sv
// Shared constants for the up/down counter: default width and direction encodings.
package up_down_counter_pkg;

  localparam int  DEFAULT_WIDTH = 4;
  localparam logic DIR_UP       = 1'b1;
  localparam logic DIR_DOWN     = 1'b0;

endpackage

// File: rtl/up_down_counter.sv
// WIDTH-bit synchronous up/down counter with enable; wraps in both directions,
// output driven straight from the count register.
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up_down,
  output logic [WIDTH-1:0] o_Q
);

  logic [WIDTH-1:0] count_p0;
  logic [WIDTH-1:0] count_nxt;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Modular add/subtract; natural truncation gives the wrap at both ends.
  always_comb begin
    count_nxt = count_p0;
    if (i_en) begin
      if (i_up_down == DIR_UP) count_nxt = count_p0 + ONE;
      else                     count_nxt = count_p0 - ONE;
    end
  end

  // Stage p0: count register, reset has priority over enable/direction
  always_ff @(posedge i_clk) begin
    if (i_rst) count_p0 <= '0;
    else       count_p0 <= count_nxt;
  end

  assign o_Q = count_p0;

endmodule

// File: tb/tb_up_down_counter.sv
// Directed self-checking bench for up_down_counter at WIDTH=4 and WIDTH=8.
module tb_up_down_counter;

  logic       clk = 1'b0;
  logic       rst4 = 1'b0, en4 = 1'b0, ud4 = 1'b1;
  logic       rst8 = 1'b0, en8 = 1'b0, ud8 = 1'b1;
  logic [3:0] q4;
  logic [7:0] q8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  up_down_counter #(.WIDTH(4)) u_dut4 (
    .i_clk    (clk),
    .i_rst    (rst4),
    .i_en     (en4),
    .i_up_down(ud4),
    .o_Q      (q4)
  );

  up_down_counter #(.WIDTH(8)) u_dut8 (
    .i_clk    (clk),
    .i_rst    (rst8),
    .i_en     (en8),
    .i_up_down(ud8),
    .o_Q      (q8)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply inputs to the 4-bit instance, take one rising edge, settle 1 time unit.
  task automatic edge4(input logic rst, input logic en, input logic ud);
    rst4 = rst; en4 = en; ud4 = ud;
    @(posedge clk); #1;
  endtask

  task automatic edge8(input logic rst, input logic en, input logic ud);
    rst8 = rst; en8 = en; ud8 = ud;
    @(posedge clk); #1;
  endtask

  int up_exp[5]     = '{1, 2, 3, 4, 5};
  int down_exp[15]  = '{4, 3, 2, 1, 0, 15, 14, 13, 12, 11, 10, 9, 8, 7, 6};
  int climb_exp[8]  = '{7, 8, 9, 10, 11, 12, 13, 14};
  int wrap_exp[3]   = '{15, 0, 1};
  int to7_exp[6]    = '{2, 3, 4, 5, 6, 7};

  initial begin
    // Reset with enable high and direction up: reset must win.
    edge4(1'b1, 1'b1, 1'b1);
    check_val("rst_w4", q4, 0);
    edge8(1'b1, 1'b1, 1'b1);
    check_val("rst_w8", q8, 0);
    rst8 = 1'b0; en8 = 1'b0;

    for (int i = 0; i < 5; i++) begin
      edge4(1'b0, 1'b1, 1'b1);
      check_val($sformatf("up_%0d", i), q4, up_exp[i]);
    end

    for (int i = 0; i < 15; i++) begin
      edge4(1'b0, 1'b1, 1'b0);
      check_val($sformatf("down_%0d", i), q4, down_exp[i]);
    end

    for (int i = 0; i < 8; i++) begin
      edge4(1'b0, 1'b1, 1'b1);
      check_val($sformatf("climb_%0d", i), q4, climb_exp[i]);
    end

    for (int i = 0; i < 3; i++) begin
      edge4(1'b0, 1'b1, 1'b1);
      check_val($sformatf("upwrap_%0d", i), q4, wrap_exp[i]);
    end

    for (int i = 0; i < 6; i++) begin
      edge4(1'b0, 1'b1, 1'b1);
      check_val($sformatf("to7_%0d", i), q4, to7_exp[i]);
    end

    // Hold for 4 edges, two in each direction.
    edge4(1'b0, 1'b0, 1'b1); check_val("hold_up_0", q4, 7);
    edge4(1'b0, 1'b0, 1'b1); check_val("hold_up_1", q4, 7);
    edge4(1'b0, 1'b0, 1'b0); check_val("hold_dn_0", q4, 7);
    edge4(1'b0, 1'b0, 1'b0); check_val("hold_dn_1", q4, 7);

    // Enable glitch strictly between edges must not count.
    #2 en4 = 1'b1;
    #2 en4 = 1'b0;
    check_val("glitch_comb", q4, 7);
    edge4(1'b0, 1'b0, 1'b1);
    check_val("glitch_hold", q4, 7);

    edge4(1'b0, 1'b1, 1'b1); check_val("resume_8", q4, 8);
    edge4(1'b0, 1'b1, 1'b1); check_val("reach_9", q4, 9);

    // Reset mid-count, then resume on the first edge after release.
    edge4(1'b1, 1'b1, 1'b1); check_val("midrst", q4, 0);
    edge4(1'b0, 1'b1, 1'b1); check_val("postrst", q4, 1);
    edge4(1'b0, 1'b1, 1'b0); check_val("reverse", q4, 0);

    // 8-bit: down wrap from 0 then up wrap from 255.
    edge8(1'b0, 1'b1, 1'b0); check_val("w8_downwrap", q8, 255);
    edge8(1'b0, 1'b1, 1'b1); check_val("w8_upwrap", q8, 0);
    edge8(1'b0, 1'b1, 1'b1); check_val("w8_up1", q8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/up_down_counter.md
UP_DOWN_COUNTER -- requirements
Module: up_down_counter

Interface
REQ-001 Parameter: WIDTH, 4, counter width in bits; legal range 1..32.
REQ-002 Port: i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: i_rst  input  1  reset; synchronous, active-high.
REQ-004 Port: i_en  input  1  count enable; 1 = count on this edge, 0 = hold.
REQ-005 Port: i_up_down  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 Port: o_Q  output  WIDTH  current count, driven directly from a register.

Function
REQ-007 The block SHALL hold a WIDTH-bit count register, and o_Q SHALL equal that register at all times, with no combinational path from inputs to o_Q.
REQ-008 On a rising i_clk edge with i_rst=1, the count SHALL become 0, regardless of i_en and i_up_down.
REQ-009 On a rising edge with i_rst=0, i_en=1 and i_up_down=1, the count SHALL become (count+1) mod 2^WIDTH.
REQ-010 On a rising edge with i_rst=0, i_en=1 and i_up_down=0, the count SHALL become (count-1) mod 2^WIDTH.
REQ-011 On a rising edge with i_rst=0 and i_en=0, the count SHALL hold its value.
REQ-012 Latency SHALL be one cycle: o_Q SHALL reflect an edge's update immediately after that edge.
REQ-013 Up wrap: the count SHALL go from 2^WIDTH-1 to 0 (15 -> 0 for WIDTH=4), with no flag or saturation.
REQ-014 Down wrap: the count SHALL go from 0 to 2^WIDTH-1 (0 -> 15 for WIDTH=4), with no flag or saturation.
REQ-015 A change of i_up_down between edges SHALL take effect at the next edge, with no dead cycle.
REQ-016 Inputs SHALL be sampled only at rising edges; mid-cycle glitches SHALL have no effect.

Reset
REQ-017 Reset SHALL be synchronous and active-high on i_rst, with priority over every other input.
REQ-018 The reset value of o_Q SHALL be 0.
REQ-019 Asserting reset mid-count SHALL force 0 at the next edge; counting SHALL resume on the first edge after deassertion.
REQ-020 Before the first reset edge, o_Q is unspecified, and the bench SHALL NOT check it.

Structure
REQ-021 A shared package up_down_counter_pkg SHALL hold the default width constant (4) and direction constants (DIR_UP=1, DIR_DOWN=0).
REQ-022 No sub-module is required; the next-count logic SHALL be one combinational block feeding one register process.
REQ-023 The design SHALL be synthesizable, with no latches, no initial blocks and no vendor primitives.

Verification
REQ-024 Reset then count up: i_en=1, i_rst=1 for one edge, then i_up_down=1 for 5 edges -> o_Q = 0, then 1, 2, 3, 4, 5.
REQ-025 Direction reversal and down wrap: from 5, set i_up_down=0 for 15 edges -> o_Q = 4, 3, 2, 1, 0, 15, 14, ... and ends at 6.
REQ-026 Up wrap: from 14 with i_up_down=1 for 3 edges -> o_Q = 15, 0, 1.
REQ-027 Hold: from 7, i_en=0 for 4 edges in either direction -> o_Q stays 7; then i_en=1 and up for one edge -> 8.
REQ-028 Reset priority: from 9 with i_en=1 and up, assert i_rst for one edge -> o_Q = 0; release it -> the next edge gives 1.
REQ-029 Width check: with WIDTH=8, from 255 count up one edge -> 0; from 0 count down one edge -> 255.
